draw_sequencer: RTL

//  Upstream controller for the circle drawer. On start it clears the 160x120

---
 rtl/draw_pkg.sv | 26 ++
 rtl/draw_sequencer_screen_clear.sv | 40 ++++
 rtl/draw_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/draw_pkg.sv
// Shared types and screen geometry for the draw sequencer and its clear scanner.
package draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef logic [7:0] pix_x_t;
    typedef logic [6:0] pix_y_t;
    typedef logic [2:0] colour_t;

    localparam colour_t BG_COLOUR = 3'b000;
    localparam pix_x_t  X_LAST    = 8'(SCREEN_W - 1);
    localparam pix_y_t  Y_LAST    = 7'(SCREEN_H - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_CIRCLE = 2'd2,
        S_DONE   = 2'd3
    } seq_state_t;

    function automatic logic is_last_pixel(input pix_x_t x, input pix_y_t y);
        return (x == X_LAST) && (y == Y_LAST);
    endfunction

endpackage

// File: rtl/draw_sequencer_screen_clear.sv
// Column-major scan counters for the background clear pass: y runs fastest,
// x advances when a column completes.
module screen_clear
    import draw_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   restart_i,
    input  logic   step_i,
    output pix_x_t x_o,
    output pix_y_t y_o,
    output logic   last_o
);

    pix_x_t x_q;
    pix_y_t y_q;

    // Scan position; restart takes priority so a new request always begins at (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= 8'd0;
            y_q <= 7'd0;
        end else if (restart_i) begin
            x_q <= 8'd0;
            y_q <= 7'd0;
        end else if (step_i) begin
            if (y_q == Y_LAST) begin
                y_q <= 7'd0;
                x_q <= (x_q == X_LAST) ? 8'd0 : x_q + 8'd1;
            end else begin
                y_q <= y_q + 7'd1;
            end
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = is_last_pixel(x_q, y_q);

endmodule

// File: rtl/draw_sequencer.sv
// Clears the screen to background, then hands the VGA plot port to the circle
// engine with parameters latched at accept, and reports done.
module draw_sequencer
    import draw_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       done,
    input  logic [2:0] colour,
    input  logic [7:0] centre_x,
    input  logic [6:0] centre_y,
    input  logic [7:0] radius,
    output logic       circ_start,
    input  logic       circ_done,
    output logic [7:0] circ_centre_x,
    output logic [6:0] circ_centre_y,
    output logic [7:0] circ_radius,
    output logic [2:0] circ_colour,
    input  logic [7:0] circ_vga_x,
    input  logic [6:0] circ_vga_y,
    input  logic [2:0] circ_vga_colour,
    input  logic       circ_vga_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    seq_state_t state_q;
    colour_t    colour_q;
    pix_x_t     centre_x_q;
    pix_y_t     centre_y_q;
    logic [7:0] radius_q;

    logic   accept_s;
    logic   step_s;
    logic   last_s;
    pix_x_t clr_x_s;
    pix_y_t clr_y_s;

    assign accept_s = (state_q == S_IDLE) && start;
    assign step_s   = (state_q == S_CLEAR);

    screen_clear u_clear (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart_i (accept_s),
        .step_i    (step_s),
        .x_o       (clr_x_s),
        .y_o       (clr_y_s),
        .last_o    (last_s)
    );

    // Sequencer FSM and parameter latches; start is only sampled in IDLE and DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            colour_q   <= 3'd0;
            centre_x_q <= 8'd0;
            centre_y_q <= 7'd0;
            radius_q   <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        colour_q   <= colour;
                        centre_x_q <= centre_x;
                        centre_y_q <= centre_y;
                        radius_q   <= radius;
                        state_q    <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (last_s) begin
                        state_q <= S_CIRCLE;
                    end
                end
                S_CIRCLE: begin
                    if (circ_done) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Plot-port ownership: scanner in CLEAR, zero-latency engine pass-through in CIRCLE.
    always_comb begin
        done       = 1'b0;
        circ_start = 1'b0;
        vga_x      = 8'd0;
        vga_y      = 7'd0;
        vga_colour = 3'd0;
        vga_plot   = 1'b0;
        case (state_q)
            S_CLEAR: begin
                vga_x      = clr_x_s;
                vga_y      = clr_y_s;
                vga_colour = BG_COLOUR;
                vga_plot   = 1'b1;
            end
            S_CIRCLE: begin
                circ_start = 1'b1;
                vga_x      = circ_vga_x;
                vga_y      = circ_vga_y;
                vga_colour = circ_vga_colour;
                vga_plot   = circ_vga_plot;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    assign circ_centre_x = centre_x_q;
    assign circ_centre_y = centre_y_q;
    assign circ_radius   = radius_q;
    assign circ_colour   = colour_q;

endmodule
